// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the RAM arbiter family.
//   arb_state_t  : ownership state (IDLE, OWN0, OWN1)
//   REQ_CPU      : index of the CPU load/store/fetch requester
//   REQ_LOADER   : index of the UART boot/DMA loader requester
//   MASK_W       : byte-mask width for the default 32-bit data path
//   mask_width() : byte-mask width for an arbitrary data width
//   own_state()  : owner index -> ownership state
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int REQ_CPU        = 0;
  localparam int REQ_LOADER     = 1;
  localparam int DEFAULT_DATA_W = 32;
  localparam int MASK_W         = DEFAULT_DATA_W / 8;

  function automatic int mask_width(input int data_w);
    return data_w / 8;
  endfunction

  function automatic arb_state_t own_state(input logic n);
    return n ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Two-way round-robin winner selection.
//   req    in  2  pending requests
//   last   in  1  index of the requester served most recently
//   winner out 1  index of the requester to serve next (don't-care if req==0)
// ---------------------------------------------------------------------------
module rr_pick
  import arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       winner
);

  // On a tie the requester that was not served last wins; otherwise the
  // only pending requester wins.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last;
    end else begin
      winner = req[REQ_LOADER];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter for the shared single-port instruction/data RAM.
// Requester 0 is the CPU, requester 1 is the UART boot/DMA loader.
// Round-robin ownership with at most BURST_MAX consecutive beats while the
// other requester waits; read data returns one cycle after the beat.
//   CLK, RESET            clock, asynchronous active-high reset
//   req_i, we_i           per-requester request / write enable
//   addr*_i, wdata*_i,
//   wmask*_i              per-requester beat payload
//   gnt_o                 one-hot registered grant
//   rvalid_o, rdata_o     read return (rdata_o qualified by rvalid_o)
//   mem_*_o, mem_rdata_i  RAM interface
// ---------------------------------------------------------------------------
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_MAX = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [ADDR_W-1:0]   addr0_i,
  input  logic [ADDR_W-1:0]   addr1_i,
  input  logic [DATA_W-1:0]   wdata0_i,
  input  logic [DATA_W-1:0]   wdata1_i,
  input  logic [DATA_W/8-1:0] wmask0_i,
  input  logic [DATA_W/8-1:0] wmask1_i,
  output logic [1:0]          gnt_o,
  output logic [1:0]          rvalid_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_wmask_o,
  output logic                mem_ren_o,
  output logic                mem_wen_o,
  input  logic [DATA_W-1:0]   mem_rdata_i
);

  localparam int         MW        = mask_width(DATA_W);
  localparam logic [7:0] LAST_BEAT = 8'(BURST_MAX - 1);

  arb_state_t state;
  logic       last;
  logic [7:0] count;
  logic       cur;
  logic       other;
  logic       accept;
  logic       pick;

  // cur is the owning requester; only meaningful outside IDLE.
  assign cur    = (state == OWN1) ? 1'(REQ_LOADER) : 1'(REQ_CPU);
  assign other  = ~cur;
  assign accept = (state != IDLE) && req_i[cur];

  rr_pick u_pick (
    .req    (req_i),
    .last   (last),
    .winner (pick)
  );

  // RAM payload follows the owner combinationally; the strobes are the only
  // outputs that must be quiet when no beat is accepted.
  always_comb begin
    mem_addr_o  = cur ? addr1_i  : addr0_i;
    mem_wdata_o = cur ? wdata1_i : wdata0_i;
    mem_wmask_o = cur ? wmask1_i[MW-1:0] : wmask0_i[MW-1:0];
    mem_ren_o   = accept & ~we_i[cur];
    mem_wen_o   = accept &  we_i[cur];
  end

  // The RAM itself supplies the one-cycle read latency.
  assign rdata_o = mem_rdata_i;

  // Ownership FSM. The count holds the number of beats already taken in this
  // tenure; once it reaches BURST_MAX-1 it saturates and the next accepted
  // beat hands over if the other side is waiting. rvalid is launched from the
  // accepted read independent of any ownership change in the same cycle.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      gnt_o    <= 2'b00;
      last     <= 1'b1;
      count    <= 8'd0;
      rvalid_o <= 2'b00;
    end else begin
      rvalid_o <= 2'b00;
      if (accept && !we_i[cur]) begin
        rvalid_o[cur] <= 1'b1;
      end

      case (state)
        IDLE: begin
          count <= 8'd0;
          if (|req_i) begin
            state <= own_state(pick);
            gnt_o <= {pick, ~pick};
          end
        end

        OWN0, OWN1: begin
          if (!req_i[cur]) begin
            last  <= cur;
            count <= 8'd0;
            if (req_i[other]) begin
              state <= own_state(other);
              gnt_o <= {other, ~other};
            end else begin
              state <= IDLE;
              gnt_o <= 2'b00;
            end
          end else if (count == LAST_BEAT) begin
            if (req_i[other]) begin
              last  <= cur;
              count <= 8'd0;
              state <= own_state(other);
              gnt_o <= {other, ~other};
            end
          end else begin
            count <= count + 8'd1;
          end
        end

        default: begin
          state <= IDLE;
          gnt_o <= 2'b00;
          count <= 8'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Self-checking bench for mem_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level ownership model and a golden RAM.
// A second instance with BURST_MAX=1 covers strict alternation.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int BURST = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic [3:0]  wmask0, wmask1;

  logic [1:0]  gnt, rvalid;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        mem_ren, mem_wen;

  logic [1:0]  gnt_b, rvalid_b;
  logic [31:0] rdata_b, mem_addr_b, mem_wdata_b;
  logic [3:0]  mem_wmask_b;
  logic        mem_ren_b, mem_wen_b;

  logic [31:0] ram    [0:255];
  logic [31:0] golden [0:255];

  int  checks = 0;
  int  errors = 0;

  int          m_owner;
  bit          m_last;
  int          m_tenure;
  logic [1:0]  exp_rvalid;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(BURST)) dut (
    .CLK(clk), .RESET(rst), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .wmask0_i(wmask0), .wmask1_i(wmask1),
    .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata),
    .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_wmask_o(mem_wmask),
    .mem_ren_o(mem_ren), .mem_wen_o(mem_wen), .mem_rdata_i(mem_rdata)
  );

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .BURST_MAX(1)) dut_b (
    .CLK(clk), .RESET(rst), .req_i(req), .we_i(we),
    .addr0_i(addr0), .addr1_i(addr1), .wdata0_i(wdata0), .wdata1_i(wdata1),
    .wmask0_i(wmask0), .wmask1_i(wmask1),
    .gnt_o(gnt_b), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
    .mem_addr_o(mem_addr_b), .mem_wdata_o(mem_wdata_b), .mem_wmask_o(mem_wmask_b),
    .mem_ren_o(mem_ren_b), .mem_wen_o(mem_wen_b), .mem_rdata_i(32'd0)
  );

  function automatic logic [31:0] init_word(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 16) return 32'hDEADBEEF;
    if (i == 32) return 32'hAAAAAAAA;
    return {b, ~b, 16'h1234};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w,
                                        input logic [31:0] new_w,
                                        input logic [3:0] mask);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  // Behavioural single-port RAM with registered read; reloads on reset.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_wen) ram[mem_addr[7:0]] <= merge(ram[mem_addr[7:0]], mem_wdata, mem_wmask);
      if (mem_ren) mem_rdata <= ram[mem_addr[7:0]];
    end
  end

  function automatic bit model_acc();
    return (m_owner == 0 && req[0]) || (m_owner == 1 && req[1]);
  endfunction

  function automatic logic [1:0] exp_gnt();
    return {m_owner == 1, m_owner == 0};
  endfunction

  task automatic model_reset();
    m_owner    = -1;
    m_last     = 1'b1;
    m_tenure   = 0;
    exp_rvalid = 2'b00;
    for (int i = 0; i < 256; i++) golden[i] = init_word(i);
  endtask

  // Advance one clock: derive the next ownership/return from the current
  // inputs using the arbitration rules, then wait for the edge.
  task automatic tick();
    int          o, m, n_owner, n_ten, a;
    bit          n_last;
    logic [1:0]  n_rv;
    logic [31:0] n_rd;
    n_owner = m_owner; n_last = m_last; n_ten = m_tenure;
    n_rv = 2'b00; n_rd = exp_rdata;
    if (m_owner < 0) begin
      if (req != 2'b00) begin
        if (req == 2'b11) n_owner = m_last ? 0 : 1;
        else              n_owner = req[1] ? 1 : 0;
        n_ten = 0;
      end
    end else begin
      o = m_owner; m = 1 - o;
      if (model_acc()) begin
        a = (o == 1) ? int'(addr1[7:0]) : int'(addr0[7:0]);
        if (we[o]) golden[a] = merge(golden[a], (o == 1) ? wdata1 : wdata0,
                                     (o == 1) ? wmask1 : wmask0);
        else begin n_rv[o] = 1'b1; n_rd = golden[a]; end
        if (m_tenure + 1 >= BURST && req[m]) begin
          n_owner = m; n_last = bit'(o); n_ten = 0;
        end else begin
          n_ten = (m_tenure + 1 > BURST) ? BURST : m_tenure + 1;
        end
      end else begin
        n_owner = req[m] ? m : -1; n_last = bit'(o); n_ten = 0;
      end
    end
    @(posedge clk); #1;
    m_owner = n_owner; m_last = n_last; m_tenure = n_ten;
    exp_rvalid = n_rv; exp_rdata = n_rd;
  endtask

  task automatic apply_reset();
    req = 2'b00; we = 2'b00;
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    req = 2'b00; we = 2'b00;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt: got %b want 00", gnt); end
    checks++; if (rvalid !== 2'b00) begin errors++; $display("[TB] FAIL reset_rvalid: got %b want 00", rvalid); end
    checks++; if (mem_ren !== 1'b0 || mem_wen !== 1'b0) begin errors++; $display("[TB] FAIL reset_strobes: got ren=%b wen=%b want 0 0", mem_ren, mem_wen); end
    checks++; if (gnt_b !== 2'b00) begin errors++; $display("[TB] FAIL reset_gnt_b: got %b want 00", gnt_b); end
    rst = 1'b0;
    tick();
    checks++; if (gnt !== 2'b00) begin errors++; $display("[TB] FAIL idle_no_req_gnt: got %b want 00", gnt); end
  endtask

  task automatic test_single_read();
    apply_reset();
    req = 2'b01; we = 2'b00; addr0 = 32'h10;
    #1;
    checks++; if (mem_ren !== 1'b0) begin errors++; $display("[TB] FAIL rd_idle_ren: got %b want 0", mem_ren); end
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rd_gnt_c1: got %b want 01", gnt); end
    checks++; if (mem_ren !== 1'b1 || mem_addr !== 32'h10) begin errors++; $display("[TB] FAIL rd_strobe_c1: got ren=%b addr=%h want 1 00000010", mem_ren, mem_addr); end
    tick();
    checks++; if (rvalid !== 2'b01) begin errors++; $display("[TB] FAIL rd_rvalid_c2: got %b want 01", rvalid); end
    checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL rd_rdata_c2: got %h want deadbeef", rdata); end
    req = 2'b00;
    tick();
    checks++; if (rvalid !== 2'b00 || gnt !== 2'b00) begin errors++; $display("[TB] FAIL rd_after_drop: got rvalid=%b gnt=%b want 00 00", rvalid, gnt); end
  endtask

  task automatic test_tie();
    apply_reset();
    req = 2'b11; we = 2'b00; addr0 = 32'h1; addr1 = 32'h2;
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL tie_first: got %b want 01", gnt); end
    tick(); tick();
    req = 2'b10;
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL tie_handover_c4: got %b want 10", gnt); end
    req = 2'b00;
    tick(); tick();
    req = 2'b11;
    tick();
    checks++; if (gnt !== exp_gnt()) begin errors++; $display("[TB] FAIL tie_second: got %b want %b", gnt, exp_gnt()); end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_burst();
    apply_reset();
    req = 2'b01; we = 2'b00; addr0 = 32'h5; addr1 = 32'h6;
    tick();
    for (int c = 1; c <= 4; c++) begin
      if (c == 2) req = 2'b11;
      #1;
      checks++; if (gnt !== 2'b01 || mem_ren !== 1'b1) begin errors++; $display("[TB] FAIL burst_beat_c%0d: got gnt=%b ren=%b want 01 1", c, gnt, mem_ren); end
      tick();
    end
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL burst_switch_c5: got %b want 10", gnt); end
    req = 2'b01;
    tick();
    for (int c = 0; c < 12; c++) begin
      checks++; if (gnt !== 2'b01 || mem_ren !== 1'b1) begin errors++; $display("[TB] FAIL stream_c%0d: got gnt=%b ren=%b want 01 1", c, gnt, mem_ren); end
      tick();
    end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_write();
    apply_reset();
    req = 2'b10; we = 2'b10; addr1 = 32'h20; wdata1 = 32'h12345678; wmask1 = 4'b0011;
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL wr_gnt: got %b want 10", gnt); end
    checks++; if (mem_wen !== 1'b1 || mem_ren !== 1'b0) begin errors++; $display("[TB] FAIL wr_strobes: got wen=%b ren=%b want 1 0", mem_wen, mem_ren); end
    checks++; if (mem_addr !== 32'h20 || mem_wdata !== 32'h12345678 || mem_wmask !== 4'b0011) begin errors++; $display("[TB] FAIL wr_payload: got %h %h %b want 00000020 12345678 0011", mem_addr, mem_wdata, mem_wmask); end
    tick();
    req = 2'b01; we = 2'b00; addr0 = 32'h20;
    #1;
    checks++; if (rvalid !== 2'b00 || mem_wen !== 1'b0) begin errors++; $display("[TB] FAIL wr_single_beat: got rvalid=%b wen=%b want 00 0", rvalid, mem_wen); end
    tick();
    checks++; if (gnt !== 2'b01 || mem_ren !== 1'b1) begin errors++; $display("[TB] FAIL wr_readback_gnt: got gnt=%b ren=%b want 01 1", gnt, mem_ren); end
    tick();
    req = 2'b00;
    checks++; if (rvalid !== 2'b01 || rdata !== 32'hAAAA5678) begin errors++; $display("[TB] FAIL wr_readback: got rvalid=%b rdata=%h want 01 aaaa5678", rvalid, rdata); end
    tick(); tick();
  endtask

  task automatic test_read_switch();
    apply_reset();
    req = 2'b11; we = 2'b00; addr0 = 32'h10; addr1 = 32'h20;
    repeat (4) tick();
    checks++; if (gnt !== 2'b01 || mem_ren !== 1'b1) begin errors++; $display("[TB] FAIL sw_last_beat: got gnt=%b ren=%b want 01 1", gnt, mem_ren); end
    tick();
    checks++; if (gnt !== 2'b10) begin errors++; $display("[TB] FAIL sw_gnt: got %b want 10", gnt); end
    checks++; if (rvalid !== 2'b01 || rdata !== 32'hDEADBEEF) begin errors++; $display("[TB] FAIL sw_rvalid: got rvalid=%b rdata=%h want 01 deadbeef", rvalid, rdata); end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    req = 2'b10; we = 2'b00; addr1 = 32'h10;
    tick();
    #3;
    checks++; if (gnt !== 2'b10 || mem_ren !== 1'b1) begin errors++; $display("[TB] FAIL rm_pre: got gnt=%b ren=%b want 10 1", gnt, mem_ren); end
    rst = 1'b1;
    model_reset();
    #1;
    checks++; if (gnt !== 2'b00 || rvalid !== 2'b00) begin errors++; $display("[TB] FAIL rm_async: got gnt=%b rvalid=%b want 00 00", gnt, rvalid); end
    @(posedge clk); #1;
    rst = 1'b0;
    req = 2'b11;
    #1;
    checks++; if (gnt !== 2'b00 || rvalid !== 2'b00) begin errors++; $display("[TB] FAIL rm_release: got gnt=%b rvalid=%b want 00 00", gnt, rvalid); end
    tick();
    checks++; if (gnt !== 2'b01) begin errors++; $display("[TB] FAIL rm_regrant: got %b want 01", gnt); end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_alternate();
    apply_reset();
    req = 2'b11; we = 2'b00;
    tick();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (gnt_b !== ((c % 2 == 0) ? 2'b01 : 2'b10)) begin
        errors++; $display("[TB] FAIL alt_c%0d: got %b want %b", c, gnt_b, (c % 2 == 0) ? 2'b01 : 2'b10);
      end
      tick();
    end
    req = 2'b00;
    tick(); tick();
  endtask

  task automatic test_random();
    bit   acc;
    logic ob;
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      req    = 2'($urandom_range(0, 3));
      we     = 2'($urandom);
      addr0  = 32'($urandom_range(0, 31));
      addr1  = 32'($urandom_range(0, 31));
      wdata0 = $urandom; wdata1 = $urandom;
      wmask0 = 4'($urandom); wmask1 = 4'($urandom);
      #1;
      acc = model_acc();
      ob  = (m_owner == 1);
      checks++; if (gnt !== exp_gnt()) begin errors++; $display("[TB] FAIL rnd_gnt@%0d: got %b want %b", c, gnt, exp_gnt()); end
      checks++; if (rvalid !== exp_rvalid) begin errors++; $display("[TB] FAIL rnd_rvalid@%0d: got %b want %b", c, rvalid, exp_rvalid); end
      if (exp_rvalid != 2'b00) begin
        checks++; if (rdata !== exp_rdata) begin errors++; $display("[TB] FAIL rnd_rdata@%0d: got %h want %h", c, rdata, exp_rdata); end
      end
      checks++; if (mem_ren !== (acc & ~we[ob]) || mem_wen !== (acc & we[ob])) begin errors++; $display("[TB] FAIL rnd_strobes@%0d: got ren=%b wen=%b want %b %b", c, mem_ren, mem_wen, acc & ~we[ob], acc & we[ob]); end
      if (acc) begin
        checks++; if (mem_addr !== (ob ? addr1 : addr0)) begin errors++; $display("[TB] FAIL rnd_addr@%0d: got %h want %h", c, mem_addr, ob ? addr1 : addr0); end
        if (we[ob]) begin
          checks++; if (mem_wdata !== (ob ? wdata1 : wdata0) || mem_wmask !== (ob ? wmask1 : wmask0)) begin errors++; $display("[TB] FAIL rnd_wpayload@%0d: got %h %b want %h %b", c, mem_wdata, mem_wmask, ob ? wdata1 : wdata0, ob ? wmask1 : wmask0); end
        end
      end
      tick();
    end
    req = 2'b00;
    tick(); tick();
  endtask

  // Hard stop in case anything stalls the sequence below.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; req = 2'b00; we = 2'b00;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0; wmask0 = '0; wmask1 = '0;
    exp_rdata = '0;
    model_reset();
    test_reset();
    test_single_read();
    test_tie();
    test_burst();
    test_write();
    test_read_switch();
    test_reset_mid();
    test_alternate();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
